// File: rtl/step_ctrl.sv
// step_ctrl: debounced step controller for a downstream 3-bit enabled register.
// The raw UP/DOWN/CLR requests are synchronised. The first accepted request
// produces one load strobe with the next value. The FSM then locks out further
// requests for HOLD_CYCLES cycles and waits until every request is released.
//
// Build option: define STEP_CTRL_WRAP_EN for modulo-8 arithmetic at the
// 0/7 boundaries. By default the arithmetic saturates and no strobe is issued
// at a boundary.
//
// Handshake: this block uses no valid/ready pair. out_EN is a single-cycle
// load strobe, and out_D holds its value until the next strobe. A request is
// a level; it is accepted only in IDLE, and it must return low before the
// next request can be accepted.
module step_ctrl #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       in_CLK,
  input  logic       in_RST_N,
  input  logic       in_UP,
  input  logic       in_DOWN,
  input  logic       in_CLR,
  input  logic [2:0] in_Q,
  output logic [2:0] out_D,
  output logic       out_EN,
  output logic       out_BUSY
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    UPDATE   = 2'd1,
    HOLD     = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  // Request bit order: [2] = clr, [1] = up, [0] = down
  logic [2:0] req_meta;
  logic [2:0] req_sync;
  logic       clr_s, up_s, down_s;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] d_d;
  logic       en_d;
  logic       busy_d;
  logic       go;
  logic [2:0] q_inc, q_dec;

  assign clr_s  = req_sync[2];
  assign up_s   = req_sync[1];
  assign down_s = req_sync[0];

  // UP and DOWN together with no CLR is ambiguous, so that case is not a request
  assign go    = clr_s | (up_s ^ down_s);
  assign q_inc = in_Q + 3'd1;
  assign q_dec = in_Q - 3'd1;

  // Two-flop synchroniser on the raw request lines
  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      req_meta <= 3'b000;
      req_sync <= 3'b000;
    end else begin
      req_meta <= {in_CLR, in_UP, in_DOWN};
      req_sync <= req_meta;
    end
  end

  // Next-state, lockout counter and next output values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = out_D;
    en_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = UPDATE;
          if (clr_s) begin
            d_d  = 3'd0;
            en_d = 1'b1;
          end else if (up_s) begin
`ifdef STEP_CTRL_WRAP_EN
            d_d  = q_inc;
            en_d = 1'b1;
`else
            d_d  = (in_Q == 3'd7) ? 3'd7 : q_inc;
            en_d = (in_Q != 3'd7);
`endif
          end else begin
`ifdef STEP_CTRL_WRAP_EN
            d_d  = q_dec;
            en_d = 1'b1;
`else
            d_d  = (in_Q == 3'd0) ? 3'd0 : q_dec;
            en_d = (in_Q != 3'd0);
`endif
          end
        end
      end
      UPDATE: begin
        state_d = HOLD;
        cnt_d   = 8'd0;
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = WAIT_REL;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_REL: begin
        if (req_sync == 3'b000) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counter and registered outputs; reset clears them without a clock
  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      out_D    <= 3'd0;
      out_EN   <= 1'b0;
      out_BUSY <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_D    <= d_d;
      out_EN   <= en_d;
      out_BUSY <= busy_d;
    end
  end

endmodule

// File: doc/step_ctrl.md
STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, lockout cycles after each update (range 1..255).
REQ-002 in_CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 in_RST_N  input  1  reset, asynchronous, active-low.
REQ-004 in_UP  input  1  raw increment request, asynchronous to in_CLK.
REQ-005 in_DOWN  input  1  raw decrement request, asynchronous to in_CLK.
REQ-006 in_CLR  input  1  raw clear request, asynchronous to in_CLK.
REQ-007 in_Q  input  3  current value fed back from the downstream 3-bit enabled register.
REQ-008 out_D  output  3  next value, driven to downstream register data input.
REQ-009 out_EN  output  1  one-cycle load strobe to downstream register enable.
REQ-010 out_BUSY  output  1  high whenever FSM is not in IDLE.

Function
REQ-011 Each of in_UP, in_DOWN, in_CLR SHALL pass through a 2-flop synchronizer before any use.
REQ-012 FSM states SHALL be IDLE, UPDATE, HOLD, WAIT_REL; registered state, one-hot or binary encoding.
REQ-013 IDLE -> UPDATE when any synchronized request is high, except UP and DOWN both high with CLR low; that case stays in IDLE.
REQ-014 Priority on entry to UPDATE: CLR > UP > DOWN.
REQ-015 On the edge entering UPDATE, out_D SHALL register: CLR -> 0; UP -> in_Q+1; DOWN -> in_Q-1, using in_Q sampled at that edge.
REQ-016 out_EN SHALL be high for exactly the one cycle spent in UPDATE; out_D SHALL hold its value until the next UPDATE.
REQ-017 Latency: a request first sampled high by the raw input flop at edge k SHALL produce out_EN high in the cycle after edge k+2.
REQ-018 UPDATE -> HOLD unconditionally after one cycle; HOLD lasts exactly HOLD_CYCLES cycles, then -> WAIT_REL.
REQ-019 WAIT_REL -> IDLE on the first edge at which all three synchronized requests are low; otherwise remain.
REQ-020 Requests arriving in UPDATE, HOLD or WAIT_REL SHALL be ignored; one press yields at most one update.
REQ-021 out_BUSY SHALL be a registered decode, high in UPDATE, HOLD, WAIT_REL.
REQ-022 Boundary values (in_Q=7 with UP, in_Q=0 with DOWN) SHALL follow REQ-030/REQ-031.

Reset
REQ-023 in_RST_N low SHALL immediately force state IDLE, out_D=0, out_EN=0, out_BUSY=0, synchronizer flops 0, hold counter 0.
REQ-024 Reset asserted during UPDATE SHALL deassert out_EN without waiting for a clock edge.
REQ-025 After reset release, the first update SHALL require a request sampled high after release (subject to REQ-017).
REQ-026 No other storage SHALL exist outside reset control.

Configuration
REQ-027 Macro STEP_CTRL_WRAP_EN selects boundary arithmetic.
REQ-028 Defined: UP at 7 -> out_D=0, DOWN at 0 -> out_D=7, out_EN pulses as normal (modulo-8).
REQ-029 Undefined: saturating arithmetic applies.
REQ-030 Undefined, UP at in_Q=7: out_D=7, out_EN SHALL stay low, FSM still runs UPDATE -> HOLD -> WAIT_REL.
REQ-031 Undefined, DOWN at in_Q=0: out_D=0, out_EN SHALL stay low, same FSM path.
REQ-032 All non-boundary behaviour SHALL be identical in both builds.

Verification
REQ-033 Reset low, then release with in_Q=3, pulse in_UP 10 cycles -> single out_EN pulse, out_D=4, 3 cycles after first sample; out_BUSY high until 2 cycles after in_UP falls, and not before HOLD ends.
REQ-034 in_Q=5, in_UP and in_CLR raised same cycle -> out_D=0, one out_EN pulse.
REQ-035 in_Q=2, in_UP and in_DOWN high together for 20 cycles -> no out_EN, out_BUSY stays 0.
REQ-036 in_Q=7, in_UP pulse -> WRAP_EN build: out_D=0, out_EN pulses; default build: out_D=7, out_EN never high, out_BUSY still cycles.
REQ-037 in_DOWN held high 50 cycles with HOLD_CYCLES=4, in_Q=6 -> exactly one out_EN, out_D=5; second press after release -> out_D=4 with in_Q=5.
REQ-038 in_RST_N driven low mid-UPDATE -> out_EN, out_BUSY, out_D fall to 0 before next in_CLK edge.
